// File: rtl/mod1601_pkg.sv
// Shared constants, types and FSM encoding for the GF(1601) inverter.
package mod1601_pkg;
  localparam int unsigned Q  = 1601;
  localparam int unsigned W  = 11;
  localparam int unsigned E  = 1599;
  localparam int unsigned MU = 2619;
  localparam int unsigned TW = 2*W + 1;

  typedef logic [W-1:0]   res_t;
  typedef logic [2*W-1:0] prod_t;
  typedef logic [TW-1:0]  wide_t;

  typedef enum logic [1:0] {IDLE, SQR, MUL, DONE} state_t;

  localparam res_t E_BITS = res_t'(E);
endpackage

// File: rtl/mod1601_mul.sv
// Combinational x*y mod 1601: 11x11 multiply, Barrett estimate, two corrections.
module mod1601_mul
  import mod1601_pkg::*;
(
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic [W-1:0] r
);
  prod_t p;
  wide_t t_full;
  logic [TW-W-1:0] t;
  prod_t tq;
  prod_t r0;
  prod_t r1;
  prod_t r2;

  always_comb begin
    p      = prod_t'(x) * prod_t'(y);
    t_full = wide_t'(p[2*W-1:W]) * wide_t'(MU);
    t      = t_full[TW-1:W];
    tq     = prod_t'(t) * prod_t'(Q);
    r0     = p - tq;
    // The truncated quotient undershoots by at most two multiples of Q.
    r1     = (r0 >= prod_t'(Q)) ? r0 - prod_t'(Q) : r0;
    r2     = (r1 >= prod_t'(Q)) ? r1 - prod_t'(Q) : r1;
    r      = r2[W-1:0];
  end
endmodule

// File: rtl/mod1601_inv.sv
// Constant-time a^(Q-2) mod 1601 via MSB-first square-and-multiply; 22 cycles from accept to out_valid.
module mod1601_inv
  import mod1601_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_r,
  output logic         out_err
);
  state_t     state;
  res_t       acc;
  res_t       base;
  logic [3:0] idx;
  res_t       mul_y;
  res_t       mul_r;

  // The multiply by 1 on a clear exponent bit keeps the schedule data-independent.
  always_comb begin
    mul_y = acc;
    if (state == MUL) mul_y = E_BITS[idx] ? base : res_t'(1);
  end

  mod1601_mul u_mul (
    .x (acc),
    .y (mul_y),
    .r (mul_r)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_r     <= '0;
      out_err   <= 1'b0;
      acc       <= res_t'(1);
      base      <= '0;
      idx       <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            base     <= (in_a >= res_t'(Q)) ? in_a - res_t'(Q) : in_a;
            acc      <= res_t'(1);
            idx      <= 4'(W-1);
            in_ready <= 1'b0;
            state    <= SQR;
          end
        end
        SQR: begin
          acc   <= mul_r;
          state <= MUL;
        end
        MUL: begin
          acc <= mul_r;
          if (idx == 4'd0) begin
            state     <= DONE;
            out_valid <= 1'b1;
            out_r     <= mul_r;
            out_err   <= (base == '0);
          end else begin
            idx   <= idx - 4'd1;
            state <= SQR;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
